adc_capture_writer: RTL and testbench
=====================================

Name: adc_capture_writer

Overview:
- Upstream feeder of the PSRAM QSPI write path.
- Takes 24-bit ADC sample pairs (two 12-bit samples per pulse) from the ADC interface and packs them densely into 16-bit words: 2 pairs become 3 words.
- Buffers the words in a small FIFO and issues one write_strobe/addr/data_in transaction per word to the memory driver, pacing on its out_ready.
- Writes a contiguous PSRAM region starting at a programmable base address, then reports done.

Parameters:
- FIFO_DEPTH, 16, depth of the word FIFO in 16-bit words; power of 2, minimum 4.
- ADDR_STEP, 2, byte-address increment per 16-bit word written.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a capture when idle, ignored otherwise
- base_addr  in  24  PSRAM byte address of the first word; latched on start
- word_count  in  16  number of 16-bit words to write; latched on start; 0 means done immediately
- adc_enable  out  1  enables the ADC interface
- pair_valid  in  1  one-cycle pulse; pair_data is valid
- pair_data  in  24  {sample_a[11:0], sample_b[11:0]}
- mem_ready  in  1  out_ready of the memory driver
- write_strobe  out  1  one-cycle write request
- addr  out  24  write address
- data_in  out  16  write data
- busy  out  1  capture in progress
- done  out  1  one-cycle pulse at completion
- overflow  out  1  sticky; at least one pair was dropped; cleared on the next accepted start

Behaviour:
- Reset values: adc_enable=0, write_strobe=0, addr=0, data_in=0, busy=0, done=0, overflow=0. FSM goes to IDLE, FIFO is emptied, packer is cleared.
- Capture FSM states: IDLE, CAPTURE, FLUSH, DRAIN, FINISH.
- IDLE: on start with word_count=0, go to FINISH. On start otherwise, latch base_addr and word_count, clear overflow and the counters, set busy, go to CAPTURE.
- CAPTURE: adc_enable=1. A pair is accepted when pair_valid=1 and FIFO free space >= 2.
- Packer, first pair P0 of a group: push P0[23:8]; hold P0[7:0].
- Packer, second pair P1 of a group: push {held, P1[23:16]} this cycle and P1[15:0] the next cycle (pending register).
- pair_valid arriving while the pending push is outstanding, or with insufficient FIFO space: pair dropped, overflow set to 1.
- pushed_count stops at word_count; extra packed words are discarded.
- CAPTURE to DRAIN when pushed_count = word_count. In the same cycle adc_enable=0.
- FLUSH: entered only if word_count is reached while the packer holds a partial word. Pushes {held, 8'h00}, then goes to DRAIN.
- DRAIN: wait for FIFO empty and the writer idle, then go to FINISH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Writer FSM states: W_IDLE, W_ISSUE, W_WAIT_BUSY, W_WAIT_READY.
- W_IDLE: when FIFO not empty and mem_ready=1, pop the word into data_in, set addr = base + ADDR_STEP*written_count (mod 2^24, wrapping), go to W_ISSUE.
- W_ISSUE: write_strobe=1 for exactly one cycle.
- W_WAIT_BUSY: wait for mem_ready=0. Timeout: if mem_ready is still 1 after 4 cycles, treat the write as accepted.
- W_WAIT_READY: wait for mem_ready=1, then increment written_count and return to W_IDLE.
- addr and data_in hold stable from W_ISSUE until W_WAIT_READY exits.
- Minimum spacing between writes is therefore 3 cycles plus the memory transaction time.
- Simultaneous push and pop is legal. FIFO full blocks accepting pairs and never blocks the writer.
- start while busy: ignored.
- Reset mid-transaction: write_strobe drops at once. The partially written region is not rolled back.

Decomposition:
- Shared package adc_mem_pkg holds:
  - state encodings for the capture and writer FSMs;
  - ADC_PAIR_W=24, MEM_WORD_W=16, MEM_ADDR_W=24;
  - the write-busy timeout constant WR_BUSY_TIMEOUT=4.
- One sub-module: sync_word_fifo. Parameterised depth, 16-bit data; ports push, pop, full, empty, free_count; asynchronous active-high reset.

Test Plan:
- Basic packing: start, base=0x000100, count=3; pairs 0xABC123 then 0x456DEF -> writes (0x100, 0xABC1), (0x102, 0x2345), (0x104, 0x6DEF); then done pulse; overflow=0.
- Odd flush: count=2; single pair 0x123456 -> writes 0x1234 at base and 0x5600 at base+2; done pulses.
- Address wrap: base=0xFFFFFE, count=2 -> addresses 0xFFFFFE then 0x000000.
- Overflow: hold mem_ready=0 and send 20 pairs at 2-cycle spacing -> FIFO fills; overflow=1 and stays 1. Release mem_ready -> exactly the buffered words are written.
- Handshake: model a driver whose out_ready drops 1 cycle after the strobe for 10 cycles -> one strobe per word; addr/data_in stable through the busy window; no strobe while mem_ready=0.
- Reset mid-run: assert rst during W_WAIT_READY -> all outputs 0 within the same cycle; a later start with count=0 -> done pulses the following cycle.

Source files
------------

// File: rtl/adc_mem_pkg.sv
// adc_mem_pkg: shared constants for the ADC capture -> PSRAM write path.
//   - data widths of the ADC pair, memory word and memory address
//   - capture and writer FSM state encodings
//   - timeout for the memory driver's busy acknowledge
package adc_mem_pkg;

    localparam int ADC_PAIR_W = 24;
    localparam int MEM_WORD_W = 16;
    localparam int MEM_ADDR_W = 24;

    // Cycles to wait for mem_ready to drop after a strobe before assuming
    // the driver took the write anyway.
    localparam int WR_BUSY_TIMEOUT = 4;

    // Capture FSM
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_FLUSH   = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    // Writer FSM
    localparam logic [1:0] W_IDLE       = 2'd0;
    localparam logic [1:0] W_ISSUE      = 2'd1;
    localparam logic [1:0] W_WAIT_BUSY  = 2'd2;
    localparam logic [1:0] W_WAIT_READY = 2'd3;

endpackage

// File: rtl/sync_word_fifo.sv
// sync_word_fifo: single-clock word FIFO with show-ahead read data.
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data write a word (ignored when full)
//   pop, pop_data   pop_data always shows the head word; pop consumes it
//                   (ignored when empty)
//   full, empty     status
//   free_count      number of free entries (0..DEPTH)
module sync_word_fifo
    import adc_mem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [MEM_WORD_W-1:0]    push_data,
    input  logic                     pop,
    output logic [MEM_WORD_W-1:0]    pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [MEM_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign free_count = FULL_CNT - count;
    assign pop_data   = mem[rd_ptr];

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_writer.sv
// adc_capture_writer: packs 24-bit ADC sample pairs into 16-bit words
// (2 pairs -> 3 words), buffers them and writes them to a contiguous PSRAM
// region through the memory driver's strobe/ready handshake.
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a capture (only honoured when idle)
//   base_addr           byte address of first word (latched on start)
//   word_count          words to write (latched on start; 0 = done at once)
//   adc_enable          ADC interface enable while samples are wanted
//   pair_valid/data     incoming {sample_a, sample_b} pair
//   mem_ready           driver ready
//   write_strobe/addr/data_in   one write request per word
//   busy, done          capture in progress / one-cycle completion pulse
//   overflow            sticky: a pair was dropped
module adc_capture_writer
    import adc_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_STEP  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    input  logic [15:0]           word_count,
    output logic                  adc_enable,
    input  logic                  pair_valid,
    input  logic [ADC_PAIR_W-1:0] pair_data,
    input  logic                  mem_ready,
    output logic                  write_strobe,
    output logic [MEM_ADDR_W-1:0] addr,
    output logic [MEM_WORD_W-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]            state;
    logic [1:0]            wstate;
    logic [15:0]           wc_q;
    logic [15:0]           pushed;
    logic                  phase;      // 1: first pair of a group seen, low byte held
    logic [7:0]            held;
    logic                  pending;    // second word of a group's second pair owed
    logic [MEM_WORD_W-1:0] pend_word;
    logic [2:0]            busy_cnt;
    logic [MEM_ADDR_W-1:0] wr_addr;

    logic                  push;
    logic [MEM_WORD_W-1:0] push_data;
    logic                  pop;
    logic [MEM_WORD_W-1:0] pop_data;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         free;

    logic cap_end;
    logic cap_open;
    logic accept;
    logic drop;

    // Capture ends when all words are pushed, or when the held partial word
    // is the last one owed: it is then padded out rather than waiting for
    // another pair.
    assign cap_end  = (pushed == wc_q) ||
                      (phase && (({1'b0, pushed} + 17'd1) == {1'b0, wc_q}));
    assign cap_open = (state == S_CAPTURE) && !cap_end;
    // Free space >= 2 guarantees room for both words of a second pair.
    assign accept   = cap_open && pair_valid && !pending && (free >= CW'(2));
    assign drop     = cap_open && pair_valid && !accept;

    assign adc_enable   = cap_open;
    assign busy         = (state == S_CAPTURE) || (state == S_FLUSH) || (state == S_DRAIN);
    assign done         = (state == S_FINISH);
    assign write_strobe = (wstate == W_ISSUE);
    assign pop          = (wstate == W_IDLE) && !empty && mem_ready;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state == S_CAPTURE) begin
            if (pending) begin
                push      = 1'b1;
                push_data = pend_word;
            end else if (accept) begin
                push      = 1'b1;
                push_data = phase ? {held, pair_data[23:16]} : pair_data[23:8];
            end
        end else if (state == S_FLUSH) begin
            push      = 1'b1;
            push_data = {held, 8'h00};
        end
        // Words beyond word_count are discarded.
        if (pushed >= wc_q || full) push = 1'b0;
    end

    sync_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .full       (full),
        .empty      (empty),
        .free_count (free)
    );

    // Capture FSM and packer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wc_q      <= '0;
            pushed    <= '0;
            phase     <= 1'b0;
            held      <= '0;
            pending   <= 1'b0;
            pend_word <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push)    pushed   <= pushed + 16'd1;
            if (drop)    overflow <= 1'b1;
            if (pending) pending  <= 1'b0;
            if (accept) begin
                if (phase) begin
                    pending   <= 1'b1;
                    pend_word <= pair_data[15:0];
                    phase     <= 1'b0;
                end else begin
                    held  <= pair_data[7:0];
                    phase <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= S_FINISH;
                        end else begin
                            wc_q     <= word_count;
                            pushed   <= '0;
                            phase    <= 1'b0;
                            pending  <= 1'b0;
                            overflow <= 1'b0;
                            state    <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (pushed == wc_q)  state <= S_DRAIN;
                    else if (cap_end)    state <= S_FLUSH;
                end
                S_FLUSH: begin
                    phase <= 1'b0;
                    state <= S_DRAIN;
                end
                S_DRAIN:  if (empty && wstate == W_IDLE) state <= S_FINISH;
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Writer FSM. One write is outstanding at a time, so advancing the
    // address on pop equals base + ADDR_STEP * words written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate   <= W_IDLE;
            addr     <= '0;
            data_in  <= '0;
            wr_addr  <= '0;
            busy_cnt <= '0;
        end else begin
            if (state == S_IDLE && start && word_count != '0) wr_addr <= base_addr;
            case (wstate)
                W_IDLE: begin
                    if (pop) begin
                        data_in <= pop_data;
                        addr    <= wr_addr;
                        wr_addr <= wr_addr + MEM_ADDR_W'(ADDR_STEP);
                        wstate  <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    busy_cnt <= '0;
                    wstate   <= W_WAIT_BUSY;
                end
                W_WAIT_BUSY: begin
                    if (!mem_ready || busy_cnt == 3'(WR_BUSY_TIMEOUT - 1))
                        wstate <= W_WAIT_READY;
                    else
                        busy_cnt <= busy_cnt + 3'd1;
                end
                W_WAIT_READY: if (mem_ready) wstate <= W_IDLE;
                default:      wstate <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_writer.sv
module tb_adc_capture_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] word_count;
    logic        adc_enable;
    logic        pair_valid;
    logic [23:0] pair_data;
    logic        mem_ready;
    logic        write_strobe;
    logic [23:0] addr;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int mem_mode = 0;   // 0: always ready, 1: held low, 2: drop 1 cycle after strobe for 10 cycles

    logic [23:0] wa[$];
    logic [15:0] wd[$];
    logic [23:0] last_a;
    logic [15:0] last_d;
    logic        prev_strobe = 1'b0;
    int          bad_strobe = 0;
    int          run_err = 0;
    int          stab_err = 0;

    always #5 clk = ~clk;

    adc_capture_writer #(.FIFO_DEPTH(16), .ADDR_STEP(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .adc_enable   (adc_enable),
        .pair_valid   (pair_valid),
        .pair_data    (pair_data),
        .mem_ready    (mem_ready),
        .write_strobe (write_strobe),
        .addr         (addr),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    // Memory driver model
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_mode == 1) begin
                mem_ready = 1'b0;
            end else if (mem_mode == 2 && write_strobe) begin
                @(posedge clk); #1 mem_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // Write monitor
    initial begin
        forever begin
            @(negedge clk);
            if (write_strobe) begin
                wa.push_back(addr);
                wd.push_back(data_in);
                last_a = addr;
                last_d = data_in;
                if (!mem_ready)  bad_strobe++;
                if (prev_strobe) run_err++;
            end else if (mem_mode == 2 && !mem_ready && !rst) begin
                if (addr !== last_a || data_in !== last_d) stab_err++;
            end
            prev_strobe = write_strobe;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cap(input logic [23:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [23:0] p);
        @(posedge clk); #1;
        pair_valid = 1'b1; pair_data = p;
        @(posedge clk); #1;
        pair_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        logic got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check(tag, got, 1'b1);
        @(negedge clk);
        check({tag, "_width"}, done, 1'b0);
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [23:0] ea, input logic [15:0] ed);
        if (idx < wa.size()) begin
            check({tag, "_addr"}, wa[idx], ea);
            check({tag, "_data"}, wd[idx], ed);
        end else begin
            check({tag, "_missing"}, idx, wa.size());
        end
    endtask

    logic [23:0] pv [20];
    logic [15:0] ew [15];

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        pair_valid = 1'b0; pair_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_adc_enable", adc_enable, 0);
        check("rst_strobe", write_strobe, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic packing
        wa.delete(); wd.delete();
        start_cap(24'h000100, 16'd3);
        @(negedge clk);
        check("basic_busy", busy, 1);
        check("basic_adc_en", adc_enable, 1);
        send_pair(24'hABC123);
        send_pair(24'h456DEF);
        wait_done("basic_done", 200);
        check("basic_nwr", wa.size(), 3);
        check_write("basic_w0", 0, 24'h000100, 16'hABC1);
        check_write("basic_w1", 1, 24'h000102, 16'h2345);
        check_write("basic_w2", 2, 24'h000104, 16'h6DEF);
        check("basic_ovf", overflow, 0);
        check("basic_idle", busy, 0);

        // Odd flush
        wa.delete(); wd.delete();
        start_cap(24'h000200, 16'd2);
        send_pair(24'h123456);
        wait_done("flush_done", 200);
        check("flush_nwr", wa.size(), 2);
        check_write("flush_w0", 0, 24'h000200, 16'h1234);
        check_write("flush_w1", 1, 24'h000202, 16'h5600);

        // Address wrap
        wa.delete(); wd.delete();
        start_cap(24'hFFFFFE, 16'd2);
        send_pair(24'h111222);
        wait_done("wrap_done", 200);
        check("wrap_nwr", wa.size(), 2);
        check_write("wrap_w0", 0, 24'hFFFFFE, 16'h1112);
        check_write("wrap_w1", 1, 24'h000000, 16'h2200);

        // Overflow: memory stalled, 20 pairs; 10 pairs fit as 15 words
        mem_mode = 1;
        repeat (3) @(posedge clk);
        wa.delete(); wd.delete();
        start_cap(24'h001000, 16'd100);
        for (int i = 0; i < 20; i++) begin
            pv[i] = 24'h135790 + 24'(i) * 24'h010203;
            send_pair(pv[i]);
        end
        for (int g = 0; g < 5; g++) begin
            ew[3*g]   = pv[2*g][23:8];
            ew[3*g+1] = {pv[2*g][7:0], pv[2*g+1][23:16]};
            ew[3*g+2] = pv[2*g+1][15:0];
        end
        @(negedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_nowrite", wa.size(), 0);
        start_cap(24'h005000, 16'd1);   // busy: must be ignored
        @(negedge clk);
        check("ovf_sticky", overflow, 1);
        check("ovf_busy", busy, 1);
        mem_mode = 0;
        repeat (180) @(posedge clk);
        @(negedge clk);
        check("ovf_nwr", wa.size(), 15);
        for (int k = 0; k < 15; k++)
            check_write($sformatf("ovf_w%0d", k), k, 24'h001000 + 24'(2 * k), ew[k]);
        check("ovf_still", overflow, 1);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Handshake with a driver that goes busy after each strobe
        mem_mode = 2;
        wa.delete(); wd.delete();
        bad_strobe = 0; run_err = 0; stab_err = 0;
        start_cap(24'h002000, 16'd3);
        send_pair(24'hABC123);
        send_pair(24'h456DEF);
        wait_done("hs_done", 400);
        check("hs_nwr", wa.size(), 3);
        check_write("hs_w0", 0, 24'h002000, 16'hABC1);
        check_write("hs_w1", 1, 24'h002002, 16'h2345);
        check_write("hs_w2", 2, 24'h002004, 16'h6DEF);
        check("hs_stable", stab_err, 0);
        check("hs_strobe_low", bad_strobe, 0);
        check("hs_strobe_width", run_err, 0);

        // Reset in W_WAIT_READY
        repeat (15) @(posedge clk);
        start_cap(24'h003000, 16'd3);
        send_pair(24'hABC123);
        send_pair(24'h456DEF);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (write_strobe) seen = 1'b1;
            end
            check("rr_strobe_seen", seen, 1);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rr_strobe", write_strobe, 0);
        check("rr_addr", addr, 0);
        check("rr_data", data_in, 0);
        check("rr_busy", busy, 0);
        check("rr_adc_en", adc_enable, 0);
        check("rr_done", done, 0);
        check("rr_ovf", overflow, 0);
        mem_mode = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        start_cap(24'h007777, 16'd0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_width", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
